// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM/WB pipeline register stage.
package pipe_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_RD_W   = 5;
   localparam int DEF_CNT_W  = 16;

   // Occupancy of the two-entry (main + skid) buffer.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_e;

endpackage : pipe_pkg

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register built as a two-entry skid buffer with flush and
// a retire counter of consumed register-writing entries.
module mem_wb_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_W   = DEF_RD_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_control,
   input  logic [RD_W-1:0]   mem_rd,
   input  logic              flush,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_control,
   output logic [RD_W-1:0]   wb_rd,
   output logic [CNT_W-1:0]  retire_count
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic                main_ctl_q, main_ctl_d, skid_ctl_q, skid_ctl_d;
   logic [RD_W-1:0]     main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                accept, pop;

   // Ready comes only from registered state, keeping wb_ready off this path.
   assign mem_ready = (state_q != FULL);
   assign wb_valid  = (state_q != EMPTY);
   assign accept    = mem_valid && mem_ready;
   assign pop       = wb_valid && wb_ready;

   assign wb_data      = wb_valid ? main_data_q : '0;
   assign wb_control   = wb_valid ? main_ctl_q  : 1'b0;
   assign wb_rd        = wb_valid ? main_rd_q   : '0;
   assign retire_count = cnt_q;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctl_d  = main_ctl_q;
      main_rd_d   = main_rd_q;
      skid_data_d = skid_data_q;
      skid_ctl_d  = skid_ctl_q;
      skid_rd_d   = skid_rd_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d     = HALF;
               main_data_d = mem_data;
               main_ctl_d  = mem_control;
               main_rd_d   = mem_rd;
            end
         end
         HALF: begin
            if (accept && pop) begin
               main_data_d = mem_data;
               main_ctl_d  = mem_control;
               main_rd_d   = mem_rd;
            end else if (accept) begin
               state_d     = FULL;
               skid_data_d = mem_data;
               skid_ctl_d  = mem_control;
               skid_rd_d   = mem_rd;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_d     = HALF;
               main_data_d = skid_data_q;
               main_ctl_d  = skid_ctl_q;
               main_rd_d   = skid_rd_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;

      // A pop in a flush cycle still retires its entry.
      cnt_d = cnt_q;
      if (pop && main_ctl_q) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Payload registers need no reset: outputs are masked whenever EMPTY.
   always_ff @(posedge clk) begin
      main_data_q <= main_data_d;
      main_ctl_q  <= main_ctl_d;
      main_rd_q   <= main_rd_d;
      skid_data_q <= skid_data_d;
      skid_ctl_q  <= skid_ctl_d;
      skid_rd_q   <= skid_rd_d;
   end

endmodule : mem_wb_stage
